// File: rtl/axi_word_io_pkg.sv
// Shared types for the single-beat AXI word I/O engine: response codes,
// size encodings, FSM states and the request legality check.
package axi_io_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] SIZE_1B  = 2'd0;
  localparam logic [1:0] SIZE_2B  = 2'd1;
  localparam logic [1:0] SIZE_4B  = 2'd2;
  localparam logic [1:0] SIZE_BAD = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    ERR  = 2'd3
  } state_e;

  // A request is legal only for sizes 1/2/4 bytes at a naturally aligned address.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_1B: bad = 1'b0;
      SIZE_2B: bad = addr_lo[0];
      SIZE_4B: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/axi_word_io_if.sv
// Single-beat AXI4 read/write channel bundle; the master modport is the
// access engine side, the slave modport is the interconnect side.
interface axi_word_io_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arsize;
  logic                    arvalid;
  logic                    arready;

  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awsize;
  logic                    awvalid;
  logic                    awready;

  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;

  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  modport master (
    output araddr, arsize, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready,
    output awaddr, awsize, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready
  );

  modport slave (
    input  araddr, arsize, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input  awaddr, awsize, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );

endinterface

// File: rtl/axi_word_io_lane_steer.sv
// Combinational byte-lane steering: bus-aligned address, write strobes,
// replicated write data and extraction of the addressed read bytes.
module axi_lane_steer
  import axi_io_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [1:0]              size,
  input  logic [31:0]             wdata_in,
  input  logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   addr_aligned,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [31:0]             rdata_out
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFS_W  = $clog2(STRB_W);

  logic [OFS_W-1:0]  ofs;
  logic [OFS_W+2:0]  bit_ofs;
  logic [STRB_W-1:0] base_strb;
  logic [31:0]       byte_mask;
  logic [31:0]       rd_window;

  assign ofs          = addr[OFS_W-1:0];
  assign bit_ofs      = {ofs, 3'b000};
  assign addr_aligned = {addr[ADDR_WIDTH-1:OFS_W], {OFS_W{1'b0}}};

  always_comb begin
    base_strb = STRB_W'(4'hF);
    byte_mask = 32'hFFFF_FFFF;
    case (size)
      SIZE_1B: begin
        base_strb = STRB_W'(4'h1);
        byte_mask = 32'h0000_00FF;
      end
      SIZE_2B: begin
        base_strb = STRB_W'(4'h3);
        byte_mask = 32'h0000_FFFF;
      end
      default: begin
        base_strb = STRB_W'(4'hF);
        byte_mask = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign wstrb = base_strb << ofs;
  assign wdata = {(DATA_WIDTH/32){wdata_in}};

  // Natural alignment keeps the enabled bytes of this window inside the bus.
  assign rd_window = rdata[bit_ofs +: 32];
  assign rdata_out = rd_window & byte_mask;

endmodule

// File: rtl/axi_word_io.sv
// Single-beat AXI4 master: one 1/2/4-byte read or write per start pulse.
// Optional watchdog enabled by defining AXI_WORD_IO_TIMEOUT_EN.
module axi_word_io
  import axi_io_pkg::*;
#(
  parameter int DATA_WIDTH     = 64,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  start,
  input  logic                  write,
  input  logic [1:0]            size,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           data_write,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            resp,
  output logic [31:0]           data_read,
  axi_word_io_if.master         m_axi
);

  localparam int STRB_W = DATA_WIDTH / 8;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            size_q;
  logic [31:0]           wdata_q;
  logic                  ar_done_q, aw_done_q, w_done_q;

  logic                  illegal;
  logic                  tmo_hit;
  logic                  ar_hs, r_hs, aw_hs, w_hs, b_hs;
  logic                  arvalid, rready, awvalid, wvalid, bready;

  logic [ADDR_WIDTH-1:0] addr_al;
  logic [STRB_W-1:0]     strb;
  logic [DATA_WIDTH-1:0] wdata_bus;
  logic [31:0]           rd_ext;

  axi_lane_steer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_lane_steer (
    .addr         (addr_q),
    .size         (size_q),
    .wdata_in     (wdata_q),
    .rdata        (m_axi.rdata),
    .addr_aligned (addr_al),
    .wstrb        (strb),
    .wdata        (wdata_bus),
    .rdata_out    (rd_ext)
  );

  assign illegal = req_illegal(size, addr[1:0]);

  // Handshakes are built from registered state so the FSM has no comb loop.
  assign ar_hs = (state_q == RD) && !ar_done_q && m_axi.arready;
  assign r_hs  = (state_q == RD) &&  ar_done_q && m_axi.rvalid;
  assign aw_hs = (state_q == WR) && !aw_done_q && m_axi.awready;
  assign w_hs  = (state_q == WR) && !w_done_q  && m_axi.wready;
  assign b_hs  = (state_q == WR) && aw_done_q && w_done_q && m_axi.bvalid;

`ifdef AXI_WORD_IO_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt_q;

  always_ff @(posedge aclk) begin
    if (!aresetn || !((state_q == RD) || (state_q == WR))) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end

  // Fires on the edge at which the counter would reach TIMEOUT_CYCLES.
  assign tmo_hit = ((state_q == RD) || (state_q == WR)) &&
                   (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    awvalid = 1'b0;
    wvalid  = 1'b0;
    bready  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (illegal)    state_d = ERR;
          else if (write) state_d = WR;
          else            state_d = RD;
        end
      end
      ERR: state_d = IDLE;
      RD: begin
        arvalid = !ar_done_q;
        rready  = ar_done_q;
        if (r_hs || tmo_hit) state_d = IDLE;
      end
      WR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
        bready  = aw_done_q && w_done_q;
        if (b_hs || tmo_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      resp      <= RESP_OKAY;
      data_read <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          ar_done_q <= 1'b0;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (start) begin
            if (illegal) begin
              done  <= 1'b1;
              error <= 1'b1;
              resp  <= RESP_SLVERR;
            end else begin
              addr_q  <= addr;
              size_q  <= size;
              wdata_q <= data_write;
            end
          end
        end
        RD: begin
          if (ar_hs) ar_done_q <= 1'b1;
          if (r_hs) begin
            done      <= 1'b1;
            error     <= |m_axi.rresp;
            resp      <= m_axi.rresp;
            data_read <= rd_ext;
          end else if (tmo_hit) begin
            done  <= 1'b1;
            error <= 1'b1;
            resp  <= RESP_DECERR;
          end
        end
        WR: begin
          if (aw_hs) aw_done_q <= 1'b1;
          if (w_hs)  w_done_q  <= 1'b1;
          if (b_hs) begin
            done  <= 1'b1;
            error <= |m_axi.bresp;
            resp  <= m_axi.bresp;
          end else if (tmo_hit) begin
            done  <= 1'b1;
            error <= 1'b1;
            resp  <= RESP_DECERR;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

  assign m_axi.araddr  = addr_al;
  assign m_axi.arsize  = {1'b0, size_q};
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = rready;
  assign m_axi.awaddr  = addr_al;
  assign m_axi.awsize  = {1'b0, size_q};
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata_bus;
  assign m_axi.wstrb   = (state_q == WR) ? strb : '0;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = bready;

endmodule

// File: tb/tb_axi_word_io.sv
// Directed bench for axi_word_io (64-bit bus): reads, writes, lane steering,
// handshake ordering, error responses, illegal requests and reset abort.
module tb_axi_word_io;

  logic        aclk;
  logic        aresetn;
  logic        start;
  logic        write;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] data_write;
  logic        busy;
  logic        done;
  logic        error;
  logic [1:0]  resp;
  logic [31:0] data_read;

  int total;
  int passed;
  int failed;
  int cyc;

  axi_word_io_if #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) axi ();

  axi_word_io #(
    .DATA_WIDTH     (64),
    .ADDR_WIDTH     (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .start      (start),
    .write      (write),
    .size       (size),
    .addr       (addr),
    .data_write (data_write),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .resp       (resp),
    .data_read  (data_read),
    .m_axi      (axi)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    total = 0; passed = 0; failed = 0;
    aresetn = 1'b0; start = 1'b0; write = 1'b0; size = 2'd0;
    addr = '0; data_write = '0;
    axi.arready = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bresp = 2'b00; axi.bvalid = 1'b0;
    tick; tick; tick;

    // Reset state
    check("rst_ctrl", {busy, done, error}, 3'b000);
    check("rst_valids", {axi.arvalid, axi.awvalid, axi.wvalid, axi.rready, axi.bready}, 5'b0);
    check("rst_resp", resp, 2'b00);
    check("rst_data_read", data_read, 32'h0);
    check("rst_addrs", {axi.araddr, axi.awaddr}, 64'h0);
    check("rst_wdata_wstrb", {axi.wdata, axi.wstrb}, 72'h0);
    aresetn = 1'b1;
    tick;

    // Read 2 bytes at 0x1006
    start = 1'b1; write = 1'b0; size = 2'd1; addr = 32'h1006;
    axi.arready = 1'b1;
    tick;
    start = 1'b0;
    check("rd_arvalid_n1", {axi.arvalid, axi.rready, busy, done}, 4'b1010);
    check("rd_araddr", axi.araddr, 32'h1000);
    check("rd_arsize", axi.arsize, 3'd1);
    axi.rvalid = 1'b1; axi.rdata = 64'h1122_3344_5566_7788; axi.rresp = 2'b00;
    tick;
    check("rd_rready_n2", {axi.arvalid, axi.rready, done}, 3'b010);
    tick;
    check("rd_done_n3", {done, error, busy}, 3'b100);
    check("rd_data", data_read, 32'h0000_1122);
    check("rd_resp", resp, 2'b00);
    axi.rvalid = 1'b0; axi.arready = 1'b0;
    tick;
    check("rd_done_drop", {done, busy}, 2'b00);
    check("rd_data_hold", data_read, 32'h0000_1122);

    // Write 4 bytes at 0x2004
    start = 1'b1; write = 1'b1; size = 2'd2; addr = 32'h2004; data_write = 32'hDEAD_BEEF;
    tick;
    start = 1'b0;
    check("wr_valids_n1", {axi.awvalid, axi.wvalid, axi.bready}, 3'b110);
    check("wr_awaddr", axi.awaddr, 32'h2000);
    check("wr_awsize", axi.awsize, 3'd2);
    check("wr_wstrb", axi.wstrb, 8'hF0);
    check("wr_wdata", axi.wdata, 64'hDEAD_BEEF_DEAD_BEEF);
    axi.awready = 1'b1; axi.wready = 1'b1;
    tick;
    check("wr_bready_n2", {axi.awvalid, axi.wvalid, axi.bready, done}, 4'b0010);
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick;
    check("wr_done_n3", {done, error, busy}, 3'b100);
    check("wr_resp", resp, 2'b00);
    axi.bvalid = 1'b0;
    tick;

    // AW accepted three cycles before W; start while busy is dropped
    start = 1'b1; write = 1'b1; size = 2'd0; addr = 32'h3001; data_write = 32'h0000_00A5;
    tick;
    start = 1'b0;
    check("skew_wstrb", axi.wstrb, 8'h02);
    check("skew_awaddr", axi.awaddr, 32'h3000);
    axi.awready = 1'b1;
    tick;
    axi.awready = 1'b0;
    start = 1'b1; write = 1'b0; size = 2'd0; addr = 32'h0;
    check("skew_aw_only", {axi.awvalid, axi.wvalid, axi.bready}, 3'b010);
    tick;
    start = 1'b0;
    check("skew_wait1", {axi.wvalid, axi.bready, done}, 3'b100);
    tick;
    axi.wready = 1'b1;
    check("skew_wait2", {axi.wvalid, axi.bready, done}, 3'b100);
    tick;
    axi.wready = 1'b0;
    check("skew_bready", {axi.wvalid, axi.bready, done}, 3'b010);
    axi.bvalid = 1'b1; axi.bresp = 2'b00;
    tick;
    axi.bvalid = 1'b0;
    check("skew_done", {done, error, busy}, 3'b100);
    tick;
    check("skew_single_done", {done, busy, axi.arvalid}, 3'b000);
    tick;
    check("busy_start_not_queued", {busy, axi.arvalid}, 2'b00);

    // Read with SLVERR response
    axi.arready = 1'b1; axi.rvalid = 1'b1; axi.rresp = 2'b10;
    axi.rdata = 64'hCAFE_BABE_1234_5678;
    start = 1'b1; write = 1'b0; size = 2'd2; addr = 32'h0000_0008;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("slverr_done", {done, error}, 2'b11);
    check("slverr_resp", resp, 2'b10);
    check("slverr_data", data_read, 32'h1234_5678);
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rresp = 2'b00;
    tick;

    // Misaligned 4-byte request
    start = 1'b1; write = 1'b0; size = 2'd2; addr = 32'h1002;
    tick;
    start = 1'b0;
    check("misalign_done_n1", {done, error, busy, axi.arvalid}, 4'b1110);
    check("misalign_resp", resp, 2'b10);
    tick;
    check("misalign_idle", {done, busy, axi.arvalid}, 3'b000);

    // size = 3 is never legal
    start = 1'b1; write = 1'b1; size = 2'd3; addr = 32'h0;
    tick;
    start = 1'b0;
    check("size3_err", {done, error, resp, axi.awvalid, axi.wvalid}, 6'b111000);
    tick;

`ifdef AXI_WORD_IO_TIMEOUT_EN
    // arready never rises: the watchdog ends the read
    start = 1'b1; write = 1'b0; size = 2'd0; addr = 32'h40;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 40) begin
      tick;
      cyc++;
    end
    check("tmo_cycles", cyc, 16);
    check("tmo_resp", {done, error, resp}, 4'b1111);
    check("tmo_arvalid", {axi.arvalid, busy}, 2'b00);
    tick;
`endif

    // Reset while W is still pending
    start = 1'b1; write = 1'b1; size = 2'd2; addr = 32'h5000; data_write = 32'h1234_5678;
    tick;
    start = 1'b0;
    check("abort_wvalid_pending", {axi.awvalid, axi.wvalid}, 2'b11);
    aresetn = 1'b0;
    tick;
    check("abort_dropped", {axi.awvalid, axi.wvalid, axi.bready, busy, done}, 5'b0);
    aresetn = 1'b1;
    tick;
    check("abort_no_done", {done, busy}, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/axi_word_io.md
# axi_word_io

Single-beat AXI4 master issuing one 1-, 2- or 4-byte read or write per `start` pulse, with the data width parametrised and AXI responses reported back. It generalises the byte-only I/O engine: natural-alignment checking, per-size strobe and lane steering, full handshake compliance and response reporting. It sits between channel-adapter control logic and the AXI interconnect and serves as the CPU-memory access path for register and buffer accesses.

## Interface
Parameters:
- `DATA_WIDTH`, default 64: AXI data bus width; legal values 32, 64 or 128.
- `ADDR_WIDTH`, default 32: AXI and host address width.
- `TIMEOUT_CYCLES`, default 1024: watchdog limit in cycles; only used when `AXI_WORD_IO_TIMEOUT_EN` is defined.

Ports (clock and reset first; `M_AXI_*` directions are from this block):
- `aclk` input 1: clock.
- `aresetn` input 1: synchronous, active-low reset.
- `start` input 1: request pulse; sampled only in IDLE.
- `write` input 1: 1 = write, 0 = read; sampled with `start`.
- `size` input 2: 0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal.
- `addr` input `ADDR_WIDTH`: byte address.
- `data_write` input 32: write data, low-aligned.
- `busy` output 1: high whenever state is not IDLE.
- `done` output 1: one-cycle completion pulse.
- `error` output 1: valid with `done`; high when `resp` is not 0 or the request was illegal.
- `resp` output 2: AXI response code, or the local error code.
- `data_read` output 32: read data, zero-extended; valid from `done` until the next read completes.
- `m_axi_ar*`: `araddr` `ADDR_WIDTH`, `arsize` 3, `arvalid` out; `arready` in.
- `m_axi_r*`: `rdata` `DATA_WIDTH`, `rresp` 2, `rvalid` in; `rready` out.
- `m_axi_aw*`: `awaddr`, `awsize` 3, `awvalid` out; `awready` in.
- `m_axi_w*`: `wdata` `DATA_WIDTH`, `wstrb` `DATA_WIDTH/8`, `wvalid` out; `wready` in.
- `m_axi_b*`: `bresp` 2, `bvalid` in; `bready` out.

## Operation
- States:
  - IDLE: wait for `start`.
  - ERR: one cycle, reports an illegal request.
  - RD: read in progress.
  - WR: write in progress.
- Transitions:
  - IDLE to ERR when `start` arrives with an illegal request. Illegal means `size` = 3, or `addr` not aligned to 2^`size` bytes.
  - IDLE to RD or WR on any other `start`. `addr`, `size`, `write` and `data_write` are latched at that edge.
  - ERR: pulses `done` with `error`=1 and `resp`=2'b10. No AXI traffic is issued. Returns to IDLE.
- Bus addressing:
  - `OFS` = `addr[log2(DATA_WIDTH/8)-1:0]`.
  - `ar/awaddr` = `addr` with the `OFS` bits cleared.
  - `ar/awsize` = `size`.
- Write data lanes:
  - `wdata` = the latched `data_write` replicated across the bus.
  - `wstrb` = ((1 << 2^`size`) - 1) << `OFS`.
- Read data: `data_read` = (`rdata` >> 8·`OFS`), masked to 2^`size` bytes.
- RD:
  - `arvalid` is held until `arready`, then dropped.
  - `rready` is asserted only after the AR handshake completes.
  - On the R handshake: latch `data_read` and `resp`=`rresp`; set `error` = (`rresp` != 0); pulse `done`; go to IDLE.
- WR:
  - `awvalid` and `wvalid` are raised together and each is dropped independently on its own handshake.
  - `bready` is asserted only after both AW and W have completed.
  - On the B handshake: `resp`=`bresp`, set `error`, pulse `done`, go to IDLE.
- All `*valid` signals and addresses/data stay stable until their handshake completes.

## Timing
- Reset values:
  - Low: `busy`, `done`, `error`, all `*valid`, `rready`, `bready`.
  - Zero: `resp`, `data_read`, `araddr`, `awaddr`, `wdata`, `wstrb`.
  - State = IDLE.
- `start` is accepted at edge N. `*valid` goes high in cycle N+1.
- Read, all ready with `rvalid` at N+2: `done` is high in cycle N+3. This is the minimum latency.
- Write, `awready`/`wready` at N+1, `bready` at N+2, `bvalid` at N+2: `done` is high in cycle N+3.
- Illegal request: `done` is high in cycle N+1.
- `start` while `busy` is ignored and not queued.
- `aresetn` low mid-transfer: all valids/readys drop at the next edge, state goes to IDLE, and `done` is not pulsed.

## Configuration
- `AXI_WORD_IO_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in RD and WR and clears in IDLE.
  - When it reaches `TIMEOUT_CYCLES`: drop all valids/readys, pulse `done` with `error`=1 and `resp`=2'b11, go to IDLE.
- `AXI_WORD_IO_TIMEOUT_EN` undefined: no counter is built, the block waits indefinitely, and `TIMEOUT_CYCLES` is ignored.

## Structure
- Package `axi_io_pkg`:
  - `resp` constants OKAY, EXOKAY, SLVERR, DECERR.
  - `size` encodings.
  - State enum (IDLE, RD, WR, ERR).
- Sub-module `axi_lane_steer`, purely combinational:
  - Inputs: address, size, write data, `rdata`.
  - Outputs: aligned address, `wstrb`, `wdata`, extracted read data.

## Test plan
- `DATA_WIDTH`=64; read `addr`=0x1006, `size`=1; `rdata`=0x1122_3344_5566_7788, `rresp`=0 -> `araddr`=0x1000, `arsize`=1, `data_read`=0x0000_1122, `error`=0, `done` in cycle N+3.
- Write `addr`=0x2004, `size`=2, `data_write`=0xDEADBEEF -> `wstrb`=0xF0, `wdata`=0xDEADBEEF_DEADBEEF, `awaddr`=0x2000.
- `awready` 3 cycles before `wready`, then `bvalid` -> `bready` rises only after both handshakes, exactly one `done`.
- `rresp`=2'b10 -> `done` with `error`=1, `resp`=2'b10.
- `size`=2 with `addr`=0x1002 -> `done` in cycle N+1, `error`=1, `resp`=2'b10, no `arvalid`.
- With `AXI_WORD_IO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16, `arready` held low -> `done` with `resp`=2'b11 after 16 cycles, `arvalid` low.
- `aresetn` pulsed while `wvalid` pending -> `wvalid`=0 at the next edge, no `done`, `busy`=0.
